// File: rtl/bpf_pkg.sv
// Shared definitions for the BPF execution core: instruction field layout,
// supported opcodes, ALU operation encoding and sequencer state encoding.
package bpf_pkg;

  // Instruction word: {code[63:48], jt[47:40], jf[39:32], k[31:0]}
  localparam int unsigned InsnW   = 64;
  localparam int unsigned CodeMsb = 63;
  localparam int unsigned CodeLsb = 48;
  localparam int unsigned JtMsb   = 47;
  localparam int unsigned JtLsb   = 40;
  localparam int unsigned JfMsb   = 39;
  localparam int unsigned JfLsb   = 32;
  localparam int unsigned KMsb    = 31;
  localparam int unsigned KLsb    = 0;

  // Loads and register moves
  localparam logic [15:0] OpLdImm  = 16'h0000;
  localparam logic [15:0] OpLdAbs  = 16'h0030;
  localparam logic [15:0] OpLdxImm = 16'h0001;
  localparam logic [15:0] OpTax    = 16'h0007;
  localparam logic [15:0] OpTxa    = 16'h0087;
  // ALU, K form / X form (bit 3 selects X as operand)
  localparam logic [15:0] OpAddK   = 16'h0004;
  localparam logic [15:0] OpAddX   = 16'h000c;
  localparam logic [15:0] OpSubK   = 16'h0014;
  localparam logic [15:0] OpSubX   = 16'h001c;
  localparam logic [15:0] OpOrK    = 16'h0044;
  localparam logic [15:0] OpOrX    = 16'h004c;
  localparam logic [15:0] OpAndK   = 16'h0054;
  localparam logic [15:0] OpAndX   = 16'h005c;
  localparam logic [15:0] OpLshK   = 16'h0064;
  localparam logic [15:0] OpLshX   = 16'h006c;
  localparam logic [15:0] OpRshK   = 16'h0074;
  localparam logic [15:0] OpRshX   = 16'h007c;
  // Jumps
  localparam logic [15:0] OpJa     = 16'h0005;
  localparam logic [15:0] OpJeq    = 16'h0015;
  localparam logic [15:0] OpJgt    = 16'h0025;
  localparam logic [15:0] OpJge    = 16'h0035;
  localparam logic [15:0] OpJset   = 16'h0045;
  // Returns
  localparam logic [15:0] OpRetK   = 16'h0006;
  localparam logic [15:0] OpRetA   = 16'h0016;

  // ALU operation select
  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluOr  = 3'd2;
  localparam logic [2:0] AluAnd = 3'd3;
  localparam logic [2:0] AluLsh = 3'd4;
  localparam logic [2:0] AluRsh = 3'd5;

  // Sequencer states
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHalt = 2'd2;

  // Map the operation nibble (code[7:4]) of an ALU instruction to an ALU op.
  function automatic logic [2:0] alu_op_of(logic [3:0] op_nib);
    logic [2:0] op;
    unique case (op_nib)
      4'h1:    op = AluSub;
      4'h4:    op = AluOr;
      4'h5:    op = AluAnd;
      4'h6:    op = AluLsh;
      4'h7:    op = AluRsh;
      default: op = AluAdd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/bpf_alu.sv
// Combinational 32-bit ALU for the BPF core.
// Ports: op (ALU operation select), a (accumulator), b (K or X operand),
//        result (a op b, modulo 2^32).
module bpf_alu
  import bpf_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (op)
      AluAdd: result = a + b;
      AluSub: result = a - b;
      AluOr:  result = a | b;
      AluAnd: result = a & b;
      // Shift counts of 32 or more clear the accumulator.
      AluLsh: result = (b >= 32'd32) ? '0 : (a << b[4:0]);
      AluRsh: result = (b >= 32'd32) ? '0 : (a >> b[4:0]);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/bpf_exec.sv
// BPF program execution core. Runs one instruction per four-phase round.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   step1..step4        one-hot phase strobes
//   start               begin a run at PC 0 (sampled on step1, ignored while running)
//   imem_addr/rdata     instruction memory, read data one clk after address
//   pkt_addr/rdata      packet byte memory, read data one clk after address
//   pkt_len             packet length in bytes
//   busy, done, ret_val, err   run status and result
module bpf_exec
  import bpf_pkg::*;
#(
  parameter int unsigned IMEM_AW = 8,
  parameter int unsigned PKT_AW  = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step1,
  input  logic               step2,
  input  logic               step3,
  input  logic               step4,
  input  logic               start,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [InsnW-1:0]   imem_rdata,
  output logic [PKT_AW-1:0]  pkt_addr,
  input  logic [7:0]         pkt_rdata,
  input  logic [PKT_AW:0]    pkt_len,
  output logic               busy,
  output logic               done,
  output logic [31:0]        ret_val,
  output logic               err
);

  // Next PC is formed wide enough that pc + 1 + k can never wrap.
  localparam int unsigned NpcW = IMEM_AW + 33;
  localparam logic [NpcW-1:0] PcLimit = {{(NpcW - IMEM_AW - 1){1'b0}}, 1'b1, {IMEM_AW{1'b0}}};

  logic [1:0]         state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [31:0]        a_q, a_d, x_q, x_d;
  logic [InsnW-1:0]   ir_q, ir_d;
  logic [PKT_AW-1:0]  pkt_addr_q, pkt_addr_d;
  logic [31:0]        ret_q, ret_d;
  logic               err_q, err_d, done_q, done_d;
  logic [31:0]        alu_q, alu_d;
  logic [NpcW-1:0]    npc_q, npc_d;

  logic [15:0]     code;
  logic [7:0]      jt, jf;
  logic [31:0]     k, offset, alu_res;
  logic [NpcW-1:0] npc;
  logic [32:0]     len_ext;
  logic            k_oob, finish, fault;

  assign code    = ir_q[CodeMsb:CodeLsb];
  assign jt      = ir_q[JtMsb:JtLsb];
  assign jf      = ir_q[JfMsb:JfLsb];
  assign k       = ir_q[KMsb:KLsb];
  assign len_ext = 33'(pkt_len);
  assign k_oob   = {1'b0, k} >= len_ext;

  bpf_alu u_alu (
    .op     (alu_op_of(code[7:4])),
    .a      (a_q),
    .b      (code[3] ? x_q : k),
    .result (alu_res)
  );

  // Branch offset relative to PC+1; zero for straight-line instructions.
  always_comb begin
    offset = '0;
    case (code)
      OpJa:    offset = k;
      OpJeq:   offset = 32'((a_q == k) ? jt : jf);
      OpJgt:   offset = 32'((a_q > k) ? jt : jf);
      OpJge:   offset = 32'((a_q >= k) ? jt : jf);
      OpJset:  offset = 32'(((a_q & k) != '0) ? jt : jf);
      default: offset = '0;
    endcase
    npc = NpcW'(pc_q) + NpcW'(offset) + NpcW'(1);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    a_d        = a_q;
    x_d        = x_q;
    ir_d       = ir_q;
    pkt_addr_d = pkt_addr_q;
    ret_d      = ret_q;
    err_d      = err_q;
    done_d     = 1'b0;
    alu_d      = alu_q;
    npc_d      = npc_q;
    finish     = 1'b0;
    fault      = 1'b0;
    case (state_q)
      StRun: begin
        if (step2) begin
          ir_d = imem_rdata;
          // Present the byte address early so the byte is back by step4.
          if (imem_rdata[CodeMsb:CodeLsb] == OpLdAbs) begin
            pkt_addr_d = imem_rdata[PKT_AW-1:0];
          end
        end
        if (step3) begin
          alu_d = alu_res;
          npc_d = npc;
        end
        if (step4) begin
          case (code)
            OpLdImm:  a_d = k;
            OpLdAbs: begin
              if (k_oob) begin
                ret_d  = '0;
                finish = 1'b1;
              end else begin
                a_d = {24'b0, pkt_rdata};
              end
            end
            OpLdxImm: x_d = k;
            OpTax:    x_d = a_q;
            OpTxa:    a_d = x_q;
            OpAddK, OpAddX, OpSubK, OpSubX, OpOrK, OpOrX,
            OpAndK, OpAndX, OpLshK, OpLshX, OpRshK, OpRshX: a_d = alu_q;
            OpJa, OpJeq, OpJgt, OpJge, OpJset: ;
            OpRetK: begin
              ret_d  = k;
              finish = 1'b1;
            end
            OpRetA: begin
              ret_d  = a_q;
              finish = 1'b1;
            end
            default: fault = 1'b1;
          endcase
          if (!finish && !fault && (npc_q >= PcLimit)) fault = 1'b1;
          if (fault) begin
            ret_d  = '0;
            err_d  = 1'b1;
            finish = 1'b1;
          end
          if (finish) begin
            state_d = StHalt;
            // PC parks at 0 so a restart fetches the first instruction on its step1.
            pc_d    = '0;
            done_d  = 1'b1;
          end else begin
            pc_d = npc_q[IMEM_AW-1:0];
          end
        end
      end
      default: begin
        if (step1 && start) begin
          state_d = StRun;
          pc_d    = '0;
          a_d     = '0;
          x_d     = '0;
          ret_d   = '0;
          err_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      a_q        <= '0;
      x_q        <= '0;
      ir_q       <= '0;
      pkt_addr_q <= '0;
      ret_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      alu_q      <= '0;
      npc_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      a_q        <= a_d;
      x_q        <= x_d;
      ir_q       <= ir_d;
      pkt_addr_q <= pkt_addr_d;
      ret_q      <= ret_d;
      err_q      <= err_d;
      done_q     <= done_d;
      alu_q      <= alu_d;
      npc_q      <= npc_d;
    end
  end

  // imem_addr follows PC directly so the fetch is already addressed during step1.
  assign imem_addr = pc_q;
  assign pkt_addr  = pkt_addr_q;
  assign busy      = (state_q == StRun);
  assign done      = done_q;
  assign ret_val   = ret_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bpf_exec.sv
module tb_bpf_exec;
  import bpf_pkg::*;

  localparam logic [63:0] FILL = 64'h0099_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        step1, step2, step3, step4;
  logic [7:0]  imem_addr;
  logic [63:0] imem_rdata;
  logic [10:0] pkt_addr;
  logic [7:0]  pkt_rdata;
  logic [11:0] pkt_len = 12'd64;
  logic        busy, done, err;
  logic [31:0] ret_val;

  logic [63:0] imem [256];
  logic [7:0]  pkt [2048];

  bpf_exec #(.IMEM_AW(8), .PKT_AW(11)) dut (
    .clk        (clk),
    .rst        (rst),
    .step1      (step1),
    .step2      (step2),
    .step3      (step3),
    .step4      (step4),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .pkt_addr   (pkt_addr),
    .pkt_rdata  (pkt_rdata),
    .pkt_len    (pkt_len),
    .busy       (busy),
    .done       (done),
    .ret_val    (ret_val),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data one clk after address.
  always @(posedge clk) begin
    imem_rdata <= imem[imem_addr];
    pkt_rdata  <= pkt[pkt_addr];
  end

  // Phase generator; gap mode inserts an idle cycle after step2 and step4.
  logic [2:0] ph = 3'd0;
  bit gap_en = 1'b0;
  always @(posedge clk) begin
    if (gap_en) ph <= (ph == 3'd5) ? 3'd0 : ph + 3'd1;
    else        ph <= (ph == 3'd1) ? 3'd3 : ((ph >= 3'd4) ? 3'd0 : ph + 3'd1);
  end
  assign step1 = (ph == 3'd0);
  assign step2 = (ph == 3'd1);
  assign step3 = (ph == 3'd3);
  assign step4 = (ph == 3'd4);

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected result pushed at start, popped on done.
  typedef struct packed {
    logic [31:0] ret;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 ret=%0h, expected no done", ret_val);
      end else begin
        e = sb_q.pop_front();
        check("ret_val", ret_val, e.ret);
        check("err", 32'(err), 32'(e.err));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  typedef struct packed {
    logic [7:0][63:0] prog;
    logic [11:0]      len;
    logic [31:0]      ret;
    logic             err;
    int               rounds;
  } vec_t;

  function automatic logic [63:0] ins(logic [15:0] c, logic [7:0] jt, logic [7:0] jf,
                                     logic [31:0] k);
    return {c, jt, jf, k};
  endfunction

  function automatic vec_t mkv(logic [11:0] len, logic [31:0] ret, logic e, int rounds,
                               logic [63:0] i0, logic [63:0] i1 = FILL,
                               logic [63:0] i2 = FILL, logic [63:0] i3 = FILL,
                               logic [63:0] i4 = FILL, logic [63:0] i5 = FILL,
                               logic [63:0] i6 = FILL, logic [63:0] i7 = FILL);
    vec_t v;
    v.prog[0] = i0; v.prog[1] = i1; v.prog[2] = i2; v.prog[3] = i3;
    v.prog[4] = i4; v.prog[5] = i5; v.prog[6] = i6; v.prog[7] = i7;
    v.len = len; v.ret = ret; v.err = e; v.rounds = rounds;
    return v;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < 256; i++) imem[i] = FILL;
    for (int i = 0; i < 8; i++) imem[i] = v.prog[i];
    pkt_len = v.len;
  endtask

  task automatic do_start();
    @(negedge clk);
    while (!step1) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Start a run and wait for done; poke re-asserts start on a step1 mid-run.
  task automatic run_vec(input vec_t v, input bit timed, input bit poke);
    exp_t e;
    int cyc;
    bit seen;
    load(v);
    e.ret = v.ret;
    e.err = v.err;
    sb_q.push_back(e);
    do_start();
    cyc = 1;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 0) check("busy_after_start", 32'(busy), 32'd1);
      if (poke && cyc == 4) start = 1'b1;
      if (poke && cyc == 5) start = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen && timed) check("run_cycles", cyc, 4 * v.rounds);
    @(negedge clk);
    check("done_one_clk", 32'(done), 32'd0);
  endtask

  vec_t vecs [20];
  int n_vec;

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) pkt[i] = 8'(i * 7 + 1);
    pkt[3] = 8'hab;
    for (int i = 0; i < 256; i++) imem[i] = FILL;

    n_vec = 0;
    vecs[n_vec++] = mkv(64, 12, 0, 3, ins(OpLdImm, 0, 0, 5), ins(OpAddK, 0, 0, 7),
                        ins(OpRetA, 0, 0, 0));
    vecs[n_vec++] = mkv(64, 1, 0, 3, ins(OpLdAbs, 0, 0, 3), ins(OpJeq, 0, 1, 32'hab),
                        ins(OpRetK, 0, 0, 1), ins(OpRetK, 0, 0, 0));
    vecs[n_vec++] = mkv(2, 0, 0, 1, ins(OpLdAbs, 0, 0, 3), ins(OpRetK, 0, 0, 9));
    vecs[n_vec++] = mkv(64, 0, 0, 4, ins(OpLdImm, 0, 0, 32'hffffffff), ins(OpAddK, 0, 0, 2),
                        ins(OpLshK, 0, 0, 40), ins(OpRetA, 0, 0, 0));
    vecs[n_vec++] = mkv(64, 1, 0, 3, ins(OpLdImm, 0, 0, 32'hffffffff), ins(OpAddK, 0, 0, 2),
                        ins(OpRetA, 0, 0, 0));
    vecs[n_vec++] = mkv(64, 0, 1, 1, ins(16'h0099, 0, 0, 0));
    vecs[n_vec++] = mkv(64, 0, 1, 1, ins(OpJa, 0, 0, 300));
    vecs[n_vec++] = mkv(64, 32'h107, 0, 7, ins(OpLdxImm, 0, 0, 3), ins(OpLdImm, 0, 0, 10),
                        ins(OpSubX, 0, 0, 0), ins(OpTax, 0, 0, 0),
                        ins(OpLdImm, 0, 0, 32'h100), ins(OpOrX, 0, 0, 0),
                        ins(OpRetA, 0, 0, 0));
    vecs[n_vec++] = mkv(64, 32'h1e, 0, 5, ins(OpLdImm, 0, 0, 32'hf0f0),
                        ins(OpAndK, 0, 0, 32'hff), ins(OpRshK, 0, 0, 4),
                        ins(OpLshK, 0, 0, 1), ins(OpRetA, 0, 0, 0));
    vecs[n_vec++] = mkv(64, 102, 0, 5, ins(OpLdImm, 0, 0, 5), ins(OpJgt, 0, 1, 5),
                        ins(OpRetK, 0, 0, 100), ins(OpJge, 1, 0, 5), ins(OpRetK, 0, 0, 101),
                        ins(OpJset, 0, 1, 4), ins(OpRetK, 0, 0, 102));
    vecs[n_vec++] = mkv(64, 32'hffffffff, 0, 3, ins(OpLdImm, 0, 0, 0), ins(OpSubK, 0, 0, 1),
                        ins(OpRetA, 0, 0, 0));
    vecs[n_vec++] = mkv(64, 2, 0, 6, ins(OpLdxImm, 0, 0, 2), ins(OpLdImm, 0, 0, 3),
                        ins(OpLshX, 0, 0, 0), ins(OpAddX, 0, 0, 0), ins(OpAndX, 0, 0, 0),
                        ins(OpRetA, 0, 0, 0));
    vecs[n_vec++] = mkv(64, 0, 0, 4, ins(OpLdxImm, 0, 0, 32), ins(OpLdImm, 0, 0, 32'hffffffff),
                        ins(OpRshX, 0, 0, 0), ins(OpRetA, 0, 0, 0));
    vecs[n_vec++] = mkv(64, 0, 1, 2, ins(OpLdImm, 0, 0, 1), ins(OpJeq, 0, 254, 0));
    vecs[n_vec++] = mkv(4, 32'hab, 0, 2, ins(OpLdAbs, 0, 0, 3), ins(OpRetA, 0, 0, 0));
    vecs[n_vec++] = mkv(3, 0, 0, 1, ins(OpLdAbs, 0, 0, 3), ins(OpRetA, 0, 0, 0));
    vecs[n_vec++] = mkv(64, 32'h55, 0, 4, ins(OpLdxImm, 0, 0, 32'h55), ins(OpTxa, 0, 0, 0),
                        ins(OpJset, 0, 1, 32'haa), ins(OpRetK, 0, 0, 1), ins(OpRetA, 0, 0, 0));
    vecs[n_vec++] = mkv(64, 2, 0, 2, ins(OpJa, 0, 0, 1), ins(OpRetK, 0, 0, 1),
                        ins(OpRetK, 0, 0, 2));
    vecs[n_vec++] = mkv(64, 0, 0, 1, ins(OpLdAbs, 0, 0, 32'h80000003), ins(OpRetK, 0, 0, 7));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ret_val", ret_val, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_pkt_addr", 32'(pkt_addr), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < n_vec; i++) run_vec(vecs[i], 1'b1, 1'b0);

    // Result and error hold after a faulting run; stray start off step1 is ignored.
    run_vec(vecs[6], 1'b1, 1'b0);
    @(negedge clk);
    while (!step2) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    check("stray_start_busy", 32'(busy), 32'd0);
    check("err_hold", 32'(err), 32'd1);
    check("ret_hold", ret_val, 32'd0);

    // Start while running is ignored: run length unchanged.
    run_vec(vecs[7], 1'b1, 1'b1);

    // Idle cycles between phases change nothing but timing.
    gap_en = 1'b1;
    run_vec(vecs[9], 1'b0, 1'b0);
    run_vec(vecs[1], 1'b0, 1'b0);
    gap_en = 1'b0;
    repeat (8) @(posedge clk);

    // Reset during round 2 abandons the run with no done pulse.
    run_vec(vecs[0], 1'b1, 1'b0);
    load(vecs[0]);
    begin
      int done_before;
      done_before = n_done;
      do_start();
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("busy_mid_run", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ret_val", ret_val, 32'd0);
      check("abort_imem_addr", 32'(imem_addr), 32'd0);
      repeat (30) @(negedge clk);
      check("abort_no_done", n_done, done_before);
    end
    run_vec(vecs[0], 1'b1, 1'b0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bpf_exec.md
BPF_EXEC -- requirements
Module: bpf_exec

Interface
REQ-001 Parameter: IMEM_AW, 8, instruction memory address width (program length 2^IMEM_AW).
REQ-002 Parameter: PKT_AW, 11, packet buffer byte-address width.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 step1..step4  in  1 each  one-hot phase strobes from the phase generator.
REQ-006 start  in  1  begin a program run at PC 0; sampled only on step1.
REQ-007 imem_addr  out  IMEM_AW  instruction address; imem_rdata  in  64  instruction word {code[63:48], jt[47:40], jf[39:32], k[31:0]}, valid one clk after imem_addr.
REQ-008 pkt_addr  out  PKT_AW  packet byte address; pkt_rdata  in  8  byte, valid one clk after pkt_addr; pkt_len  in  PKT_AW+1  packet length in bytes.
REQ-009 busy  out  1  run in progress; done  out  1  one-clk pulse at end of run; ret_val  out  32  returned value; err  out  1  run ended abnormally.

Function
REQ-010 State machine IDLE, RUN, HALT; IDLE->RUN on step1&start; RUN->HALT on RET, fault or out-of-range load; HALT->RUN on step1&start (restart at PC 0, A=X=0, err cleared).
REQ-011 start outside step1, or while RUN, is ignored.
REQ-012 One instruction per four-phase round: step1 drive imem_addr=PC; step2 latch imem_rdata into IR; step3 execute, drive pkt_addr=k[PKT_AW-1:0] for loads; step4 capture pkt_rdata, write A/X, update PC.
REQ-013 Clock cycles with no step strobe asserted change no state.
REQ-014 Supported codes: 0x00 LD imm, 0x30 LD byte abs (A = zero-extended byte), 0x01 LDX imm, 0x07 TAX, 0x87 TXA.
REQ-015 ALU (K form / X form): ADD 0x04/0x0c, SUB 0x14/0x1c, OR 0x44/0x4c, AND 0x54/0x5c, LSH 0x64/0x6c, RSH 0x74/0x7c; 32-bit, wrap-around modulo 2^32.
REQ-016 Shift amount >= 32 yields A = 0.
REQ-017 Jumps: 0x05 JA (PC = PC+1+k); JEQ 0x15, JGT 0x25, JGE 0x35, JSET 0x45 compare A with k unsigned (JSET: A&k != 0); true PC = PC+1+jt, false PC = PC+1+jf.
REQ-018 Non-jump instructions: PC = PC+1.
REQ-019 RET: 0x06 ret_val = k, 0x16 ret_val = A; done pulses on the step4 cycle; err = 0.
REQ-020 LD abs with k >= pkt_len: ret_val = 0, done pulses, err = 0 (packet reject, not fault).
REQ-021 Fault: unsupported code, or next PC >= 2^IMEM_AW (computed in IMEM_AW+33 bits, no wrap); ret_val = 0, err = 1, done pulses.
REQ-022 busy = 1 exactly while in RUN; ret_val and err hold until next run start.
REQ-023 done high exactly one clk per run.

Reset
REQ-024 rst forces state IDLE, PC=0, A=0, X=0, IR=0, imem_addr=0, pkt_addr=0, busy=0, done=0, ret_val=0, err=0.
REQ-025 rst mid-run abandons the run without a done pulse; rst has priority over any strobe.

Structure
REQ-026 Package bpf_pkg holds opcode constants, instruction field positions/widths and state encoding.
REQ-027 Sub-module bpf_alu (combinational: op, A, operand -> result) is instantiated once; jump comparison and sequencing stay in bpf_exec.

Verification
REQ-028 Program {LD imm 5; ADD K 7; RET A}, start -> done after 3 rounds (12 clks), ret_val=12, err=0.
REQ-029 pkt byte[3]=0xAB, pkt_len=64, {LD abs 3; JEQ K 0xAB jt=0 jf=1; RET K 1; RET K 0} -> ret_val=1.
REQ-030 pkt_len=2, {LD abs 3; RET K 9} -> ret_val=0, err=0, done after round 1.
REQ-031 {LD imm 0xFFFFFFFF; ADD K 2; LSH K 40; RET A} -> ret_val=0; {LD imm 0xFFFFFFFF; ADD K 2; RET A} -> ret_val=1.
REQ-032 Code 0x99 at PC 0 -> err=1, ret_val=0; JA k=300 -> err=1.
REQ-033 rst asserted during round 2 of REQ-028 -> busy=0, no done; subsequent start -> ret_val=12.
